burst_streamer: RTL
===================

Name: burst_streamer

Overview:
- Downstream consumer of the control-register block's `size` and `brst` outputs.
- Moves `size` 32-bit words from an upstream word source to the I2C byte-serialiser front end, in bursts of `brst` words.
- Buffers through a two-bank ping-pong store, so one bank fills while the other drains.
- Marks the last word of each burst and pulses `done` when the transfer completes.

Parameters:
- DEPTH, 16, words per bank; it is also the maximum effective burst length.
- AW, 4, index width; DEPTH = 2**AW.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; latches `size`/`brst` and begins a transfer.
- size  input  32  total words to transfer (from control registers).
- brst  input  32  words per burst (from control registers).
- in_valid  input  1  upstream word valid.
- in_data  input  32  upstream word.
- in_ready  output  1  block accepts `in_data` this cycle.
- out_valid  output  1  downstream word valid.
- out_data  output  32  downstream word.
- out_last  output  1  `out_data` is the final word of its burst.
- out_ready  input  1  downstream accepts the word.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when the last word is accepted downstream.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; both bank-full flags clear; write and read bank pointers go to 0; all counters go to 0.
  - in_ready, out_valid, out_last, busy and done are all 0.
  - Reset mid-transfer abandons the transfer; buffered data is discarded.
- Effective burst length: blen = DEPTH if brst==0 or brst>DEPTH, else brst[AW:0].
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - On start, latch in_rem=out_rem=size and blen.
  - If size==0, go to FINISH; otherwise go to RUN. busy=1 from the next cycle.
  - start is ignored outside IDLE.
- Write side (RUN):
  - in_ready = !full[wb] && in_rem!=0.
  - A transfer happens when in_valid && in_ready. It writes bank[wb][wptr], increments wptr and decrements in_rem.
  - The current bank's fill target is min(blen, in_rem at bank start); the value is held in a per-bank length register.
  - When the word reaching the target is written, at that edge: set full[wb], record the bank length, clear wptr, toggle wb.
- Read side (RUN):
  - out_valid = full[rb].
  - out_data = bank[rb][rptr], combinational from the register array.
  - out_last = out_valid && (rptr == len[rb]-1).
  - A transfer happens when out_valid && out_ready. It increments rptr and decrements out_rem.
  - On the last word of a bank: clear full[rb], clear rptr, toggle rb.
- Latency: the bank completes at edge N; out_valid is 1 in the cycle after edge N (no bypass).
- Simultaneous events:
  - A write that fills one bank and a read that empties the other can occur in the same cycle; both take effect.
  - Set and clear of the same full flag cannot coincide: writes only target a non-full bank.
- Back-pressure: out_data and out_last are stable while out_valid && !out_ready.
- When in_rem==0, in_ready stays 0 even if a bank is free.
- Completion: the edge where out_rem goes 1→0 moves the FSM to FINISH.
- FINISH lasts one cycle with done=1 and busy=1, then returns to IDLE with busy=0.
- Arithmetic: size is treated as unsigned 32-bit; counters do not wrap past 0.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, FINISH=2'd2);
  - DEPTH/AW defaults;
  - the blen clamp function.
- Natural sub-module: pingpong_bank. It holds the 2×DEPTH×32 register array, the full flags and the length registers, with separate write-port and read-port bank/index inputs.
- The FSM and counters stay in burst_streamer.

Test Plan:
- Baseline: size=10, brst=4, in_valid=1 continuously, out_ready=1 → 10 words out in order; out_last on words 4, 8, 10; done pulses once; busy falls the cycle after done.
- Zero size: size=0, start → no in_ready; done=1 on the cycle after start; no out_valid.
- Clamp: brst=0 and brst=40 with DEPTH=16, size=20 → bursts of 16+4; out_last on words 16 and 20.
- Back-pressure: size=8, brst=4, out_ready=0 for 20 cycles → in_ready drops after 8 words accepted (both banks full); out_data/out_last held stable; then releasing out_ready drains 8 words.
- Ping-pong overlap: size=32, brst=8, in_valid toggling 1/0 each cycle, out_ready=1 → a bank fills while the other drains; order preserved; no lost or duplicated words.
- Mid-transfer reset: rst_n=0 for 1 cycle after 5 words out of size=12 → all outputs 0 next cycle; a new start with size=3 completes normally.

Source files
------------

// File: rtl/burst_streamer_pkg.sv
// Shared definitions for the burst streamer: FSM encoding, default
// geometry and the burst-length clamp.
package burst_streamer_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // A burst of zero or one longer than a bank means "use a whole bank".
  function automatic logic [31:0] clamp_blen(input logic [31:0] brst,
                                             input logic [31:0] depth);
    if (brst == 32'd0 || brst > depth) return depth;
    else                               return brst;
  endfunction

endpackage

// File: rtl/burst_streamer_pingpong_bank.sv
// Two-bank word store. Each bank has a full flag and the number of valid
// words it holds. The write port fills one bank while the read port drains
// the other; the controller only ever writes to a bank that is not full.
module burst_streamer_pingpong_bank
  import burst_streamer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [31:0]   i_wr_data,
  input  logic          i_wr_fill,
  input  logic [AW:0]   i_wr_len,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_idx,
  input  logic          i_rd_clr,
  output logic [1:0]    o_full,
  output logic [31:0]   o_rd_data,
  output logic [AW:0]   o_rd_len
);

  logic [31:0] r_mem [0:1][0:DEPTH-1];
  logic [1:0]  r_full;
  logic [AW:0] r_len [0:1];

  // Data storage; contents are don't-care until a bank is marked full.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
  end

  // Full flags and bank lengths; fill and drain always target different banks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full   <= 2'b00;
      r_len[0] <= '0;
      r_len[1] <= '0;
    end else begin
      if (i_wr_fill) begin
        r_full[i_wr_bank] <= 1'b1;
        r_len[i_wr_bank]  <= i_wr_len;
      end
      if (i_rd_clr) r_full[i_rd_bank] <= 1'b0;
    end
  end

  assign o_full    = r_full;
  assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];
  assign o_rd_len  = r_len[i_rd_bank];

endmodule

// File: rtl/burst_streamer.sv
// Moves `size` words from an upstream source to the byte serialiser in
// bursts of `brst` words, through a ping-pong bank pair. out_last marks the
// final word of each bank; done pulses once the last word is taken.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | filling and draining banks
// FINISH | one-cycle done pulse
module burst_streamer
  import burst_streamer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] size,
  input  logic [31:0] brst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  state_t      r_state, w_next;
  logic [31:0] r_in_rem, r_out_rem;
  logic [AW:0] r_blen;
  logic        r_wb, r_rb;
  logic [AW-1:0] r_wptr, r_rptr;

  logic        w_run;
  logic [1:0]  w_full;
  logic [AW:0] w_rd_len;
  logic [AW:0] w_wcount;
  logic        w_wr_fire, w_wr_fill;
  logic        w_rd_fire, w_rd_last;

  assign w_run    = (r_state == S_RUN);
  assign w_wcount = {1'b0, r_wptr} + (AW+1)'(1);

  // A bank closes on the word that reaches the burst length or ends the input.
  assign in_ready  = w_run && !w_full[r_wb] && (r_in_rem != 32'd0);
  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_fill = w_wr_fire && ((w_wcount == r_blen) || (r_in_rem == 32'd1));

  assign out_valid = w_run && w_full[r_rb];
  assign w_rd_last = ({1'b0, r_rptr} == (w_rd_len - (AW+1)'(1)));
  assign out_last  = out_valid && w_rd_last;
  assign w_rd_fire = out_valid && out_ready;

  burst_streamer_pingpong_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_fire),
    .i_wr_bank (r_wb),
    .i_wr_idx  (r_wptr),
    .i_wr_data (in_data),
    .i_wr_fill (w_wr_fill),
    .i_wr_len  (w_wcount),
    .i_rd_bank (r_rb),
    .i_rd_idx  (r_rptr),
    .i_rd_clr  (w_rd_fire && w_rd_last),
    .o_full    (w_full),
    .o_rd_data (out_data),
    .o_rd_len  (w_rd_len)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (size == 32'd0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_rd_fire && (r_out_rem == 32'd1)) w_next = S_FINISH;
      end
      S_FINISH: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer counters and bank/index pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_rem  <= '0;
      r_out_rem <= '0;
      r_blen    <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_in_rem  <= size;
      r_out_rem <= size;
      r_blen    <= (AW+1)'(clamp_blen(brst, DEPTH));
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else if (w_run) begin
      if (w_wr_fire) begin
        r_in_rem <= r_in_rem - 32'd1;
        if (w_wr_fill) begin
          r_wptr <= '0;
          r_wb   <= ~r_wb;
        end else begin
          r_wptr <= r_wptr + AW'(1);
        end
      end
      if (w_rd_fire) begin
        r_out_rem <= r_out_rem - 32'd1;
        if (w_rd_last) begin
          r_rptr <= '0;
          r_rb   <= ~r_rb;
        end else begin
          r_rptr <= r_rptr + AW'(1);
        end
      end
    end
  end

endmodule
